// File: rtl/uart_tx_if.sv
// Byte-request / serial-line bundle between bus-side logic and the UART transmitter.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       uart_data_out;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start, tx_byte,
        input  uart_data_out, tx_busy, tx_done
    );

    modport slave (
        input  tx_start, tx_byte,
        output uart_data_out, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first; define UART_TX_PARITY_EN to insert an even-parity bit before stop.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | line high, waiting for tx_start
//   START_BIT | line low for one bit time
//   DATA_BITS | line = shadow[idx], idx 0..7, one bit time each
//   PARITY    | line = ^shadow (only with UART_TX_PARITY_EN)
//   STOP_BIT  | line high for one bit time
//   CLEANUP   | single cycle, tx_done pulse
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int UART_RATE = 115200
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / UART_RATE;
    localparam logic [15:0] CNT_LOAD     = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STOP    = 3'd3;
    localparam logic [2:0] ST_CLEANUP = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY  = 3'd5;
`endif

    logic [2:0]  state_q,  state_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [2:0]  idx_q,    idx_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        line_q,   line_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;

    // Bit timer is a down-counter reloaded at every bit boundary; zero marks the last cycle of a bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (bus.tx_start) begin
                    shadow_d = bus.tx_byte;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = CNT_LOAD;
                    idx_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = CNT_LOAD;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = 16'd0;
                    state_d = ST_CLEANUP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_CLEANUP: begin
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state they describe.
    always_comb begin
        line_d = 1'b1;
        case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shadow_d[idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_d = ^shadow_d;
`endif
            default:   line_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_CLEANUP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shadow_q <= 8'd0;
            line_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            line_q   <= line_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.uart_data_out = line_q;
    assign bus.tx_busy       = busy_q;
    assign bus.tx_done       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at 10 clocks per bit; build with UART_TX_PARITY_EN for the 8E1 variant.
module tb_uart_tx;

    localparam int C = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if bus ();

    uart_tx #(
        .CLK_FREQ (1_000_000),
        .UART_RATE(100_000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic [10:0] exp_q[$];
    int          start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.tx_done) done_cnt <= done_cnt + 1;
        if (bus.tx_busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample k of a frame sits at bit k: start, data LSB first, [parity], stop.
    function automatic logic [10:0] frame(input logic [7:0] b, input logic par);
        if (NB == 11) return {1'b1, par, b, 1'b0};
        else          return {1'b0, 1'b1, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b, input logic push, input logic par);
        @(posedge clk); #1;
        bus.tx_start = 1'b1;
        bus.tx_byte  = b;
        if (push) exp_q.push_back(frame(b, par));
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
    endtask

    // Monitor: detect start-bit falling edge, sample mid-bit, check tx_done timing, pop scoreboard.
    initial begin : monitor
        logic        prev;
        logic        ab;
        logic [10:0] smp;
        logic [10:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !bus.uart_data_out) begin
                start_q.push_back(cyc);
                smp = '0;
                ab  = 1'b0;
                for (int k = 0; k < NB; k++) begin
                    for (int j = 0; j < ((k == 0) ? C / 2 : C); j++) begin
                        @(negedge clk);
                        if (rst) ab = 1'b1;
                    end
                    if (ab) break;
                    smp[k] = bus.uart_data_out;
                end
                if (!ab) begin
                    for (int j = 0; j < C / 2 - 1; j++) begin
                        @(negedge clk);
                        if (rst) ab = 1'b1;
                    end
                end
                if (!ab) begin
                    check("done_before_end", {31'd0, bus.tx_done}, 32'd0);
                    @(negedge clk);
                    check("done_pulse", {31'd0, bus.tx_done}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL frame_expected: got frame %0h, scoreboard empty", smp);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bits", {21'd0, smp}, {21'd0, e});
                    end
                end
            end
            prev = bus.uart_data_out;
        end
    end

    initial begin : stim
        int d0, b0, s0;
        bus.tx_start = 1'b0;
        bus.tx_byte  = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // T1 reset
        check("rst_line", {31'd0, bus.uart_data_out}, 32'd1);
        check("rst_busy", {31'd0, bus.tx_busy}, 32'd0);
        check("rst_done", {31'd0, bus.tx_done}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("idle_line", {31'd0, bus.uart_data_out}, 32'd1);
        check("idle_no_done", done_cnt, 32'd0);

        // T2 single byte
        d0 = done_cnt;
        b0 = busy_cnt;
        send(8'hA5, 1'b1, 1'b0);
        repeat (NB * C + 10) @(posedge clk);
        #1;
        check("t2_done_count", done_cnt - d0, 32'd1);
        check("t2_busy_cycles", busy_cnt - b0, NB * C + 1);

        // T3 back-to-back with tx_start held
        d0 = done_cnt;
        s0 = start_q.size();
        @(posedge clk); #1;
        bus.tx_start = 1'b1;
        bus.tx_byte  = 8'h00;
        exp_q.push_back(frame(8'h00, 1'b0));
        exp_q.push_back(frame(8'hFF, 1'b0));
        @(posedge clk); #1;
        bus.tx_byte = 8'hFF;
        repeat (150) @(posedge clk);
        #1 bus.tx_start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("t3_done_count", done_cnt - d0, 32'd2);
        check("t3_frame_count", start_q.size() - s0, 32'd2);
        if (start_q.size() - s0 == 2)
            check("t3_frame_period", start_q[s0 + 1] - start_q[s0], NB * C + 2);

        // T4 start while busy is ignored
        d0 = done_cnt;
        send(8'h81, 1'b1, 1'b0);
        repeat (33) @(posedge clk);
        #1;
        bus.tx_start = 1'b1;
        bus.tx_byte  = 8'h3C;
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        repeat (NB * C + 20) @(posedge clk);
        #1;
        check("t4_done_count", done_cnt - d0, 32'd1);
        check("t4_line_idle", {31'd0, bus.uart_data_out}, 32'd1);
        check("t4_busy_idle", {31'd0, bus.tx_busy}, 32'd0);

        // T5 reset mid-frame, then a full frame
        d0 = done_cnt;
        send(8'h55, 1'b0, 1'b0);
        repeat (44) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_line", {31'd0, bus.uart_data_out}, 32'd1);
        check("t5_rst_busy", {31'd0, bus.tx_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_done", done_cnt - d0, 32'd0);
        send(8'h55, 1'b1, 1'b0);
        repeat (NB * C + 10) @(posedge clk);
        #1;
        check("t5_done_count", done_cnt - d0, 32'd1);

`ifdef UART_TX_PARITY_EN
        // T6 odd-weight byte gives parity 1
        d0 = done_cnt;
        send(8'h01, 1'b1, 1'b1);
        repeat (NB * C + 10) @(posedge clk);
        #1;
        check("t6_done_count", done_cnt - d0, 32'd1);
`endif

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
